// File: rtl/normshift_pipe.sv
// rtl/normshift_pipe.sv - pipelined left/right/normalize shifter with valid/ready handshake
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   Flush               kills every in-flight item at the next edge
//   InValid/InReady     input handshake
//   ShiftIn, ShiftAmt   operand and shift amount (amount ignored when normalizing)
//   Mode                00 left, 01 right+sticky, 10 normalize-left, 11 behaves as 00
//   InTag               sideband tag carried with the item
//   OutValid/OutReady   output handshake
//   Shifted, Sticky     shifted value and OR of bits discarded by a right shift
//   ShiftCnt            applied shift amount (leading-zero count when normalizing)
//   Zero                normalize of an all-zero operand
//   OutTag              tag of the presented result

module normshift_pipe #(
    parameter int WIDTH  = 128,
    parameter int LOGW   = $clog2(WIDTH),
    parameter int STAGES = 2,
    parameter int TAGW   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Flush,
    input  logic              InValid,
    output logic              InReady,
    input  logic [WIDTH-1:0]  ShiftIn,
    input  logic [LOGW-1:0]   ShiftAmt,
    input  logic [1:0]        Mode,
    input  logic [TAGW-1:0]   InTag,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [WIDTH-1:0]  Shifted,
    output logic              Sticky,
    output logic [LOGW-1:0]   ShiftCnt,
    output logic              Zero,
    output logic [TAGW-1:0]   OutTag
);

    // Shifter levels handled per stage; level k shifts by 2^k.
    localparam int P = (LOGW + STAGES - 1) / STAGES;

    // Leading-zero count; an all-zero operand reports 0 (Zero flags it instead).
    function automatic logic [LOGW-1:0] lzc(input logic [WIDTH-1:0] x);
        logic [LOGW-1:0] n;
        logic            found;
        n     = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && x[i]) begin
                found = 1'b1;
                n     = LOGW'(WIDTH - 1 - i);
            end
        end
        return n;
    endfunction

    // Applies levels lo..hi-1 of the log shifter; returns {sticky, data}.
    function automatic logic [WIDTH:0] shift_levels(
        input logic [WIDTH-1:0] din,
        input logic             st_in,
        input logic [LOGW-1:0]  amt,
        input logic             right,
        input int               lo,
        input int               hi
    );
        logic [WIDTH-1:0] d;
        logic             st;
        d  = din;
        st = st_in;
        for (int k = 0; k < LOGW; k++) begin
            if (k >= lo && k < hi && amt[k]) begin
                if (right) begin
                    st = st | (|(d & ~({WIDTH{1'b1}} << (1 << k))));
                    d  = d >> (1 << k);
                end else begin
                    d = d << (1 << k);
                end
            end
        end
        return {st, d};
    endfunction

    // Front end: mode decode, LZC, out-of-range pre-clear.
    logic             norm_f;
    logic             right_f;
    logic             zero_f;
    logic             oor_f;
    logic             sticky_f;
    logic [LOGW-1:0]  lzc_f;
    logic [LOGW-1:0]  amt_f;
    logic [WIDTH-1:0] data_f;

    assign norm_f   = (Mode == 2'b10);
    assign right_f  = (Mode == 2'b01);
    assign lzc_f    = lzc(ShiftIn);
    assign amt_f    = norm_f ? lzc_f : ShiftAmt;
    assign zero_f   = norm_f & ~(|ShiftIn);
    // Amounts past the datapath width (non-power-of-two WIDTH) shift everything out.
    assign oor_f    = (int'(amt_f) >= WIDTH);
    assign data_f   = oor_f ? '0 : ShiftIn;
    assign sticky_f = oor_f & right_f & (|ShiftIn);

    // Per-stage register views collected for cross-stage wiring.
    logic [STAGES-1:0] v_s;
    logic [STAGES-1:0] adv;
    logic [WIDTH-1:0]  data_s  [STAGES];
    logic [STAGES-1:0] sticky_s;
    logic [STAGES-1:0] right_s;
    logic [STAGES-1:0] zero_s;
    logic [LOGW-1:0]   amt_s   [STAGES];
    logic [TAGW-1:0]   tag_s   [STAGES];

    // A stage may advance if it or any later stage holds a bubble, or the sink takes the head.
    always_comb begin
        adv = '0;
        for (int s = 0; s < STAGES; s++) begin
            adv[s] = OutReady;
            for (int j = s; j < STAGES; j++) begin
                if (!v_s[j]) adv[s] = 1'b1;
            end
        end
    end

    assign InReady = adv[0] & ~Flush & ~reset;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        logic             st_in;
        logic             r_in;
        logic             z_in;
        logic             v_in;
        logic [LOGW-1:0]  a_in;
        logic [TAGW-1:0]  t_in;
        logic [WIDTH:0]   res;

        logic             v_q;
        logic [WIDTH-1:0] data_q;
        logic             sticky_q;
        logic             right_q;
        logic             zero_q;
        logic [LOGW-1:0]  amt_q;
        logic [TAGW-1:0]  tag_q;

        if (s == 0) begin : g_first
            assign d_in  = data_f;
            assign st_in = sticky_f;
            assign r_in  = right_f;
            assign z_in  = zero_f;
            assign a_in  = amt_f;
            assign t_in  = InTag;
            assign v_in  = InValid & InReady;
        end else begin : g_rest
            assign d_in  = data_s[s-1];
            assign st_in = sticky_s[s-1];
            assign r_in  = right_s[s-1];
            assign z_in  = zero_s[s-1];
            assign a_in  = amt_s[s-1];
            assign t_in  = tag_s[s-1];
            assign v_in  = v_s[s-1];
        end

        assign res = shift_levels(d_in, st_in, a_in, r_in, s * P,
                                  ((s + 1) * P > LOGW) ? LOGW : (s + 1) * P);

        always_ff @(posedge clk) begin
            if (reset) begin
                v_q      <= 1'b0;
                data_q   <= '0;
                sticky_q <= 1'b0;
                right_q  <= 1'b0;
                zero_q   <= 1'b0;
                amt_q    <= '0;
                tag_q    <= '0;
            end else begin
                if (Flush) begin
                    v_q <= 1'b0;
                end else if (adv[s]) begin
                    v_q <= v_in;
                end
                // Data only moves with a real item so bubbles leave the last result untouched.
                if (adv[s] && v_in) begin
                    data_q   <= res[WIDTH-1:0];
                    sticky_q <= res[WIDTH];
                    right_q  <= r_in;
                    zero_q   <= z_in;
                    amt_q    <= a_in;
                    tag_q    <= t_in;
                end
            end
        end

        assign v_s[s]      = v_q;
        assign data_s[s]   = data_q;
        assign sticky_s[s] = sticky_q;
        assign right_s[s]  = right_q;
        assign zero_s[s]   = zero_q;
        assign amt_s[s]    = amt_q;
        assign tag_s[s]    = tag_q;
    end

    assign OutValid = v_s[STAGES-1];
    assign Shifted  = data_s[STAGES-1];
    assign Sticky   = sticky_s[STAGES-1];
    assign ShiftCnt = amt_s[STAGES-1];
    assign Zero     = zero_s[STAGES-1];
    assign OutTag   = tag_s[STAGES-1];

endmodule

// File: tb/tb_normshift_pipe.sv
// tb/tb_normshift_pipe.sv - directed self-checking bench for normshift_pipe
module tb_normshift_pipe;

    logic        clk;
    logic        reset;
    logic        a_flush;
    logic        a_in_valid;
    logic        a_in_ready;
    logic [15:0] a_shift_in;
    logic [3:0]  a_amt;
    logic [1:0]  a_mode;
    logic [3:0]  a_tag;
    logic        a_out_valid;
    logic        a_out_ready;
    logic [15:0] a_shifted;
    logic        a_sticky;
    logic [3:0]  a_cnt;
    logic        a_zero;
    logic [3:0]  a_out_tag;

    logic        b_flush;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [11:0] b_shift_in;
    logic [3:0]  b_amt;
    logic [1:0]  b_mode;
    logic [3:0]  b_tag;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [11:0] b_shifted;
    logic        b_sticky;
    logic [3:0]  b_cnt;
    logic        b_zero;
    logic [3:0]  b_out_tag;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    normshift_pipe #(.WIDTH(16), .LOGW(4), .STAGES(2), .TAGW(4)) dut_a (
        .clk(clk), .reset(reset), .Flush(a_flush),
        .InValid(a_in_valid), .InReady(a_in_ready),
        .ShiftIn(a_shift_in), .ShiftAmt(a_amt), .Mode(a_mode), .InTag(a_tag),
        .OutValid(a_out_valid), .OutReady(a_out_ready),
        .Shifted(a_shifted), .Sticky(a_sticky), .ShiftCnt(a_cnt),
        .Zero(a_zero), .OutTag(a_out_tag)
    );

    normshift_pipe #(.WIDTH(12), .LOGW(4), .STAGES(3), .TAGW(4)) dut_b (
        .clk(clk), .reset(reset), .Flush(b_flush),
        .InValid(b_in_valid), .InReady(b_in_ready),
        .ShiftIn(b_shift_in), .ShiftAmt(b_amt), .Mode(b_mode), .InTag(b_tag),
        .OutValid(b_out_valid), .OutReady(b_out_ready),
        .Shifted(b_shifted), .Sticky(b_sticky), .ShiftCnt(b_cnt),
        .Zero(b_zero), .OutTag(b_out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic offer_a(input logic [1:0] mode, input logic [15:0] din,
                           input logic [3:0] amt, input logic [3:0] tag);
        a_in_valid = 1'b1;
        a_mode     = mode;
        a_shift_in = din;
        a_amt      = amt;
        a_tag      = tag;
    endtask

    // One item through the 2-stage instance; results visible on return.
    task automatic run_a(input logic [1:0] mode, input logic [15:0] din,
                         input logic [3:0] amt, input logic [3:0] tag);
        offer_a(mode, din, amt, tag);
        tick();
        a_in_valid = 1'b0;
        check("a_lat_early", 32'(a_out_valid), 0);
        tick();
        check("a_lat_valid", 32'(a_out_valid), 1);
        check("a_tag", 32'(a_out_tag), 32'(tag));
    endtask

    // One item through the 3-stage instance; results visible on return.
    task automatic run_b(input logic [1:0] mode, input logic [11:0] din,
                         input logic [3:0] amt, input logic [3:0] tag);
        b_in_valid = 1'b1;
        b_mode     = mode;
        b_shift_in = din;
        b_amt      = amt;
        b_tag      = tag;
        tick();
        b_in_valid = 1'b0;
        check("b_lat1", 32'(b_out_valid), 0);
        tick();
        check("b_lat2", 32'(b_out_valid), 0);
        tick();
        check("b_lat3_valid", 32'(b_out_valid), 1);
        check("b_tag", 32'(b_out_tag), 32'(tag));
    endtask

    initial begin
        reset       = 1'b1;
        a_flush     = 1'b0;
        a_in_valid  = 1'b0;
        a_shift_in  = '0;
        a_amt       = '0;
        a_mode      = '0;
        a_tag       = '0;
        a_out_ready = 1'b0;
        b_flush     = 1'b0;
        b_in_valid  = 1'b0;
        b_shift_in  = '0;
        b_amt       = '0;
        b_mode      = '0;
        b_tag       = '0;
        b_out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_inready", 32'(a_in_ready), 0);
        check("rst_outvalid", 32'(a_out_valid), 0);
        check("rst_shifted", 32'(a_shifted), 0);
        check("rst_sticky", 32'(a_sticky), 0);
        check("rst_cnt", 32'(a_cnt), 0);
        check("rst_zero", 32'(a_zero), 0);
        check("rst_tag", 32'(a_out_tag), 0);
        reset = 1'b0;
        #1;
        check("post_rst_inready", 32'(a_in_ready), 1);

        // Mode 00 left shift
        a_out_ready = 1'b1;
        run_a(2'b00, 16'h0013, 4'd5, 4'd1);
        check("m00_shifted", 32'(a_shifted), 'h260);
        check("m00_sticky", 32'(a_sticky), 0);
        check("m00_cnt", 32'(a_cnt), 5);

        // Mode 01 right shift with sticky
        run_a(2'b01, 16'h00A5, 4'd3, 4'd2);
        check("m01a_shifted", 32'(a_shifted), 'h14);
        check("m01a_sticky", 32'(a_sticky), 1);
        run_a(2'b01, 16'h00A8, 4'd3, 4'd3);
        check("m01b_shifted", 32'(a_shifted), 'h15);
        check("m01b_sticky", 32'(a_sticky), 0);

        // Mode 10 normalize
        run_a(2'b10, 16'h0013, 4'd2, 4'd4);
        check("m10_shifted", 32'(a_shifted), 'h9800);
        check("m10_cnt", 32'(a_cnt), 11);
        check("m10_zero", 32'(a_zero), 0);
        run_a(2'b10, 16'h0000, 4'd7, 4'd5);
        check("m10z_shifted", 32'(a_shifted), 0);
        check("m10z_cnt", 32'(a_cnt), 0);
        check("m10z_zero", 32'(a_zero), 1);

        // Mode 11 behaves as left shift
        run_a(2'b11, 16'h8001, 4'd1, 4'd6);
        check("m11_shifted", 32'(a_shifted), 'h2);
        check("m11_sticky", 32'(a_sticky), 0);

        // Backpressure: drain, then tags 0..3 against a stalled sink
        tick();
        check("bp_empty", 32'(a_out_valid), 0);
        a_out_ready = 1'b0;
        offer_a(2'b00, 16'd1, 4'd1, 4'd0);
        #1;
        check("bp_rdy0", 32'(a_in_ready), 1);
        tick();
        offer_a(2'b00, 16'd2, 4'd1, 4'd1);
        #1;
        check("bp_rdy1", 32'(a_in_ready), 1);
        tick();
        offer_a(2'b00, 16'd3, 4'd1, 4'd2);
        #1;
        check("bp_full_rdy", 32'(a_in_ready), 0);
        check("bp_head_valid", 32'(a_out_valid), 1);
        check("bp_head_tag", 32'(a_out_tag), 0);
        check("bp_head_data", 32'(a_shifted), 'h2);
        tick();
        check("bp_hold_rdy", 32'(a_in_ready), 0);
        check("bp_hold_tag", 32'(a_out_tag), 0);
        check("bp_hold_data", 32'(a_shifted), 'h2);
        tick();
        check("bp_hold2_tag", 32'(a_out_tag), 0);
        check("bp_hold2_cnt", 32'(a_cnt), 1);
        a_out_ready = 1'b1;
        #1;
        check("bp_pass_rdy", 32'(a_in_ready), 1);
        tick();
        check("bp_out1_valid", 32'(a_out_valid), 1);
        check("bp_out1_tag", 32'(a_out_tag), 1);
        check("bp_out1_data", 32'(a_shifted), 'h4);
        offer_a(2'b00, 16'd4, 4'd1, 4'd3);
        tick();
        a_in_valid = 1'b0;
        check("bp_out2_tag", 32'(a_out_tag), 2);
        check("bp_out2_data", 32'(a_shifted), 'h6);
        tick();
        check("bp_out3_valid", 32'(a_out_valid), 1);
        check("bp_out3_tag", 32'(a_out_tag), 3);
        check("bp_out3_data", 32'(a_shifted), 'h8);
        tick();
        check("bp_drained", 32'(a_out_valid), 0);

        // Flush with two items in flight
        a_out_ready = 1'b0;
        offer_a(2'b00, 16'd6, 4'd1, 4'd5);
        tick();
        offer_a(2'b00, 16'd7, 4'd1, 4'd6);
        tick();
        offer_a(2'b00, 16'd8, 4'd1, 4'd7);
        a_flush = 1'b1;
        #1;
        check("fl_inready", 32'(a_in_ready), 0);
        check("fl_pre_valid", 32'(a_out_valid), 1);
        tick();
        a_flush = 1'b0;
        check("fl_valid_cleared", 32'(a_out_valid), 0);
        a_out_ready = 1'b1;
        offer_a(2'b00, 16'd9, 4'd1, 4'd8);
        tick();
        a_in_valid = 1'b0;
        check("fl_new_early", 32'(a_out_valid), 0);
        tick();
        check("fl_new_valid", 32'(a_out_valid), 1);
        check("fl_new_tag", 32'(a_out_tag), 8);
        check("fl_new_data", 32'(a_shifted), 'h12);
        tick();
        check("fl_no_ghost", 32'(a_out_valid), 0);

        // Reset with two items in flight
        a_out_ready = 1'b0;
        offer_a(2'b00, 16'd10, 4'd1, 4'd9);
        tick();
        offer_a(2'b00, 16'd11, 4'd1, 4'd10);
        tick();
        offer_a(2'b00, 16'd12, 4'd1, 4'd11);
        reset = 1'b1;
        #1;
        check("mr_inready", 32'(a_in_ready), 0);
        tick();
        reset = 1'b0;
        check("mr_valid_cleared", 32'(a_out_valid), 0);
        check("mr_shifted_cleared", 32'(a_shifted), 0);
        check("mr_tag_cleared", 32'(a_out_tag), 0);
        a_out_ready = 1'b1;
        offer_a(2'b00, 16'd13, 4'd1, 4'd12);
        tick();
        a_in_valid = 1'b0;
        check("mr_new_early", 32'(a_out_valid), 0);
        tick();
        check("mr_new_valid", 32'(a_out_valid), 1);
        check("mr_new_tag", 32'(a_out_tag), 12);
        check("mr_new_data", 32'(a_shifted), 'h1a);
        tick();
        check("mr_no_ghost", 32'(a_out_valid), 0);

        // WIDTH=12, STAGES=3: out-of-range amounts and an in-range right shift
        run_b(2'b00, 12'hFFF, 4'd13, 4'd1);
        check("b_oor_left_shifted", 32'(b_shifted), 0);
        check("b_oor_left_sticky", 32'(b_sticky), 0);
        run_b(2'b01, 12'h001, 4'd13, 4'd2);
        check("b_oor_right_shifted", 32'(b_shifted), 0);
        check("b_oor_right_sticky", 32'(b_sticky), 1);
        check("b_oor_right_cnt", 32'(b_cnt), 13);
        run_b(2'b01, 12'h801, 4'd11, 4'd3);
        check("b_r11_shifted", 32'(b_shifted), 'h1);
        check("b_r11_sticky", 32'(b_sticky), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/normshift_pipe.md
# normshift_pipe

Pipelined, parametrised normalization shifter for the FPU postprocessing path. Extends the combinational left-shift normalizer with three modes: explicit left shift, right shift with sticky collection, and self-normalize via an internal leading-zero count. It also adds a configurable number of register stages and a valid/ready elastic handshake. It sits between the FMA/divsqrt/convert result muxing and the rounding logic, so shift latency can be traded against clock period.

## Interface
- WIDTH, default 128: shifter data width (any value >= 4; need not be a power of two).
- LOGW, default $clog2(WIDTH): shift-amount width.
- STAGES, default 2: number of register stages; legal range 1..LOGW.
- TAGW, default 4: width of the sideband tag carried alongside each item.

- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- Flush  in  1  synchronous pipeline kill.
- InValid  in  1  input item present.
- InReady  out  1  block accepts the input item this cycle.
- ShiftIn  in  WIDTH  value to shift.
- ShiftAmt  in  LOGW  shift amount; ignored in mode 10.
- Mode  in  2  00 = left logical, 01 = right logical with sticky, 10 = normalize-left, 11 = reserved (treated as 00).
- InTag  in  TAGW  sideband tag, passed through unchanged.
- OutValid  out  1  result present.
- OutReady  in  1  downstream accepts the result.
- Shifted  out  WIDTH  shifted result.
- Sticky  out  1  OR of all bits shifted out (mode 01 only; 0 otherwise).
- ShiftCnt  out  LOGW  applied shift amount: ShiftAmt in modes 00/01, leading-zero count in mode 10.
- Zero  out  1  mode 10 with ShiftIn == 0.
- OutTag  out  TAGW  tag of the result.

## Operation
- **Shifter structure.** Log shifter with LOGW levels; level k shifts by 2^k. Levels are distributed LSB-first, P = ceil(LOGW/STAGES) per stage. Stage s performs levels s*P .. min(LOGW, (s+1)*P)-1 and then registers its outputs. The last stage's register drives the outputs.
- **Out-of-range amounts.** An amount >= WIDTH (possible only for non-power-of-two WIDTH) yields Shifted = 0. In mode 01 it also sets Sticky = |ShiftIn.
- **Sticky.** Each right-shift level ORs the bits it discards into a per-item sticky bit. That bit travels with the item and accumulates across stages.
- **Mode 10.** The LZC of ShiftIn is computed combinationally before stage 0 and used as the shift amount. For ShiftIn == 0: Zero = 1, ShiftCnt = 0, Shifted = 0.
- **Stage advance.** Each stage has a valid bit V[s].
  - Adv[STAGES-1] = !V[STAGES-1] | OutReady.
  - Adv[s] = !V[s] | Adv[s+1].
  - A stage register loads only when Adv[s] is 1. Bubbles collapse.
- **Input handshake.** InReady = Adv[0] & !Flush & !reset. An item is accepted when InValid & InReady.
- **Output handshake.** OutValid = V[STAGES-1]. A result is consumed when OutValid & OutReady.
- **Flush.** Clears every V[s] at the next edge. Data registers are not cleared. An input presented in the same cycle is not accepted.
- **Reset.** Clears all V[s] and all data/tag/sticky registers. After reset: OutValid = 0, Shifted = 0, Sticky = 0, ShiftCnt = 0, Zero = 0, OutTag = 0. InReady = 0 while reset is high and 1 in the first cycle after.
- **Reset mid-operation.** All in-flight items are dropped, with the same behaviour as Flush.
- **Item integrity.** Items leave in acceptance order, never duplicated, never dropped except by Flush or reset.

## Timing
- Latency: an item accepted at edge N appears with OutValid = 1 after edge N+STAGES-1, i.e. it is visible STAGES cycles after acceptance with an unstalled pipeline.
- Throughput: one item per cycle when OutReady stays high.
- Stall rule: while OutValid & !OutReady, all outputs (Shifted, Sticky, ShiftCnt, Zero, OutTag) hold stable.
- Full pipeline: with all STAGES items held and OutReady = 0, InReady = 0.
- Simultaneous consume and accept: when OutReady = 1 on a full pipeline, InReady = 1 the same cycle.
- Combinational paths:
  - The ready chain is combinational from OutReady to InReady.
  - The stage-0 path includes the LZC plus P shifter levels.
  - No other input-to-output combinational path exists.

## Test plan
Configuration: WIDTH = 16, STAGES = 2 (P = 2) unless stated.

1. Mode 00, ShiftIn = 16'h0013, ShiftAmt = 5, OutReady = 1 -> two cycles later: Shifted = 16'h0260, Sticky = 0, ShiftCnt = 5.
2. Mode 01, ShiftAmt = 3:
   - ShiftIn = 16'h00A5 -> Shifted = 16'h0014, Sticky = 1.
   - ShiftIn = 16'h00A8 -> Shifted = 16'h0015, Sticky = 0.
3. Mode 10:
   - ShiftIn = 16'h0013 -> Shifted = 16'h9800, ShiftCnt = 11, Zero = 0.
   - ShiftIn = 0 -> Shifted = 0, ShiftCnt = 0, Zero = 1.
4. Backpressure: offer tags 0..3 back-to-back with OutReady = 0 for 4 cycles.
   - Required: tags 0 and 1 are accepted, then InReady = 0, and tag 0's outputs stay stable.
   - After OutReady = 1: tags 0, 1, 2, 3 emerge in order on consecutive cycles.
5. Flush (and, separately, reset) asserted with 2 items in flight -> OutValid = 0 next cycle, and neither item ever appears. A new item accepted the cycle after appears 2 cycles later.
6. WIDTH = 12, LOGW = 4, STAGES = 3, ShiftAmt = 13:
   - Mode 00, ShiftIn = 12'hFFF -> Shifted = 0.
   - Mode 01, ShiftIn = 12'h001 -> Shifted = 0, Sticky = 1, latency 3 cycles.
